axis_xgmii_tx_32b: RTL and testbench

//  AXI4-Stream to 32-bit XGMII transmitter: frames upstream payload beats onto a 4-lane XGMII TX bus.

---
 rtl/axis_xgmii_tx_32b.sv | 162 ++++++++++++++++
 tb/tb_axis_xgmii_tx_32b.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/axis_xgmii_tx_32b.sv
// AXI4-Stream to 32-bit XGMII transmitter: adds start/preamble/SFD and terminate,
// enforces a minimum inter-frame gap and flags underrun / illegal tkeep.
module axis_xgmii_tx_32b #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int IFG_WORDS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] xgmii_data,
  output logic [CTRL_WIDTH-1:0] xgmii_ctrl,
  output logic                  axis_tready,
  input  logic                  axis_tvalid,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  input  logic                  axis_tlast,
  input  logic [CTRL_WIDTH-1:0] axis_tkeep,
  output logic                  error_tlast_tkeep,
  output logic                  error_underrun
);

  // state | meaning
  // IDLE  | idles on the bus, waiting for tvalid to open a frame
  // PRE   | preamble/SFD word going out
  // DATA  | one payload beat per cycle, no stalls allowed
  // TERM  | full-word terminate after a tkeep=F last beat
  // IFG   | IFG_WORDS idle words before the next start
  // DROP  | frame aborted; draining upstream beats up to tlast

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("axis_xgmii_tx_32b: DATA_WIDTH must be 32");
  end
  if (CTRL_WIDTH != DATA_WIDTH / 8) begin : g_bad_ctrl
    $error("axis_xgmii_tx_32b: CTRL_WIDTH must be DATA_WIDTH/8");
  end
  if (IFG_WORDS < 1 || IFG_WORDS > 15) begin : g_bad_ifg
    $error("axis_xgmii_tx_32b: IFG_WORDS must be 1..15");
  end

  localparam logic [31:0] D_IDLE  = 32'h0707_0707;
  localparam logic [31:0] D_START = 32'h5555_55FB;
  localparam logic [31:0] D_PRE   = 32'hD555_5555;
  localparam logic [31:0] D_TERM  = 32'h0707_07FD;
  localparam logic [31:0] D_ERR   = 32'hFEFE_FEFE;
  localparam logic [3:0]  IFG_LOAD = 4'(IFG_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    TERM,
    IFG,
    DROP
  } state_t;

  state_t     state;
  logic [3:0] ifg_cnt;

  assign axis_tready = (state == DATA) || (state == DROP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      xgmii_data        <= D_IDLE;
      xgmii_ctrl        <= 4'hF;
      error_tlast_tkeep <= 1'b0;
      error_underrun    <= 1'b0;
      ifg_cnt           <= 4'd0;
    end else begin
      error_tlast_tkeep <= 1'b0;
      error_underrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (axis_tvalid) begin
            xgmii_data <= D_START;
            xgmii_ctrl <= 4'h1;
            state      <= PRE;
          end else begin
            xgmii_data <= D_IDLE;
            xgmii_ctrl <= 4'hF;
          end
        end
        PRE: begin
          xgmii_data <= D_PRE;
          xgmii_ctrl <= 4'h0;
          state      <= DATA;
        end
        DATA: begin
          if (!axis_tvalid) begin
            xgmii_data     <= D_ERR;
            xgmii_ctrl     <= 4'hF;
            error_underrun <= 1'b1;
            state          <= DROP;
          end else if (!axis_tlast) begin
            if (axis_tkeep == 4'hF) begin
              xgmii_data <= axis_tdata;
              xgmii_ctrl <= 4'h0;
            end else begin
              xgmii_data        <= D_ERR;
              xgmii_ctrl        <= 4'hF;
              error_tlast_tkeep <= 1'b1;
              state             <= DROP;
            end
          end else begin
            // Last beat: partial words carry /T/ right after the final valid byte.
            ifg_cnt <= IFG_LOAD;
            state   <= IFG;
            case (axis_tkeep)
              4'hF: begin
                xgmii_data <= axis_tdata;
                xgmii_ctrl <= 4'h0;
                state      <= TERM;
              end
              4'h1: begin
                xgmii_data <= {16'h0707, 8'hFD, axis_tdata[7:0]};
                xgmii_ctrl <= 4'hE;
              end
              4'h3: begin
                xgmii_data <= {8'h07, 8'hFD, axis_tdata[15:0]};
                xgmii_ctrl <= 4'hC;
              end
              4'h7: begin
                xgmii_data <= {8'hFD, axis_tdata[23:0]};
                xgmii_ctrl <= 4'h8;
              end
              default: begin
                xgmii_data        <= D_ERR;
                xgmii_ctrl        <= 4'hF;
                error_tlast_tkeep <= 1'b1;
              end
            endcase
          end
        end
        TERM: begin
          xgmii_data <= D_TERM;
          xgmii_ctrl <= 4'hF;
          ifg_cnt    <= IFG_LOAD;
          state      <= IFG;
        end
        IFG: begin
          xgmii_data <= D_IDLE;
          xgmii_ctrl <= 4'hF;
          if (ifg_cnt == 4'd0) state <= IDLE;
          else ifg_cnt <= ifg_cnt - 4'd1;
        end
        DROP: begin
          xgmii_data <= D_IDLE;
          xgmii_ctrl <= 4'hF;
          if (axis_tvalid && axis_tlast) begin
            ifg_cnt <= IFG_LOAD;
            state   <= IFG;
          end
        end
        default: begin
          xgmii_data <= D_IDLE;
          xgmii_ctrl <= 4'hF;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_xgmii_tx_32b.sv
// Directed bench for axis_xgmii_tx_32b: each registered word is compared against
// hand-computed XGMII data/ctrl plus the two error pulses.
module tb_axis_xgmii_tx_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] xgmii_data;
  logic [3:0]  xgmii_ctrl;
  logic        axis_tready;
  logic        axis_tvalid;
  logic [31:0] axis_tdata;
  logic        axis_tlast;
  logic [3:0]  axis_tkeep;
  logic        error_tlast_tkeep;
  logic        error_underrun;

  int n_cmp = 0;
  int n_bad = 0;

  axis_xgmii_tx_32b #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .IFG_WORDS(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .xgmii_data        (xgmii_data),
    .xgmii_ctrl        (xgmii_ctrl),
    .axis_tready       (axis_tready),
    .axis_tvalid       (axis_tvalid),
    .axis_tdata        (axis_tdata),
    .axis_tlast        (axis_tlast),
    .axis_tkeep        (axis_tkeep),
    .error_tlast_tkeep (error_tlast_tkeep),
    .error_underrun    (error_underrun)
  );

  always #5 clk = ~clk;

  // {error_tlast_tkeep, error_underrun, ctrl, data}
  logic [37:0] obs;
  assign obs = {error_tlast_tkeep, error_underrun, xgmii_ctrl, xgmii_data};

  localparam logic [37:0] W_I = {2'b00, 4'hF, 32'h0707_0707};
  localparam logic [37:0] W_S = {2'b00, 4'h1, 32'h5555_55FB};
  localparam logic [37:0] W_P = {2'b00, 4'h0, 32'hD555_5555};
  localparam logic [37:0] W_T = {2'b00, 4'hF, 32'h0707_07FD};
  localparam logic [37:0] W_E_UN = {2'b01, 4'hF, 32'hFEFE_FEFE};
  localparam logic [37:0] W_E_TK = {2'b10, 4'hF, 32'hFEFE_FEFE};

  function automatic logic [37:0] wd(input logic [31:0] d);
    return {2'b00, 4'h0, d};
  endfunction

  task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
    axis_tvalid = v;
    axis_tdata  = d;
    axis_tkeep  = k;
    axis_tlast  = l;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    #1;
    chk("reset_word", obs, W_I);
    chk("reset_tready", 38'(axis_tready), 38'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("idle_word", obs, W_I);

    // 1: two full beats, full-word terminate
    drive(1'b1, 32'h4433_2211, 4'hF, 1'b0);
    tick(); chk("t1_s", obs, W_S);
    chk("t1_tready_pre", 38'(axis_tready), 38'd0);
    tick(); chk("t1_p", obs, W_P);
    chk("t1_tready_data", 38'(axis_tready), 38'd1);
    tick(); chk("t1_d0", obs, wd(32'h4433_2211));
    drive(1'b1, 32'h8877_6655, 4'hF, 1'b1);
    tick(); chk("t1_d1", obs, wd(32'h8877_6655));
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick(); chk("t1_t", obs, W_T);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("t1_ifg%0d", i), obs, W_I);
    end
    tick(); chk("t1_idle", obs, W_I);

    // 2: single beat, tkeep=3
    drive(1'b1, 32'h0000_BBAA, 4'h3, 1'b1);
    tick(); chk("t2_s", obs, W_S);
    tick(); chk("t2_p", obs, W_P);
    tick(); chk("t2_term", obs, {2'b00, 4'hC, 32'h07FD_BBAA});
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("t2_ifg%0d", i), obs, W_I);
    end

    // 3: back-to-back single-beat frames with tvalid held high
    drive(1'b1, 32'hA1A2_A3A4, 4'hF, 1'b1);
    tick(); chk("t3_s0", obs, W_S);
    tick(); chk("t3_p0", obs, W_P);
    tick(); chk("t3_d0", obs, wd(32'hA1A2_A3A4));
    tick(); chk("t3_t0", obs, W_T);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("t3_ifg%0d", i), obs, W_I);
      chk($sformatf("t3_ifg_tready%0d", i), 38'(axis_tready), 38'd0);
    end
    tick(); chk("t3_s1", obs, W_S);
    tick(); chk("t3_p1", obs, W_P);
    tick(); chk("t3_d1", obs, wd(32'hA1A2_A3A4));
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick(); chk("t3_t1", obs, W_T);
    repeat (3) tick();

    // 4: underrun on the 2nd of 4 beats, rest drained
    drive(1'b1, 32'h1111_1111, 4'hF, 1'b0);
    tick(); chk("t4_s", obs, W_S);
    tick(); chk("t4_p", obs, W_P);
    tick(); chk("t4_d0", obs, wd(32'h1111_1111));
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick(); chk("t4_err", obs, W_E_UN);
    chk("t4_drop_tready", 38'(axis_tready), 38'd1);
    drive(1'b1, 32'h3333_3333, 4'hF, 1'b0);
    tick(); chk("t4_drain0", obs, W_I);
    drive(1'b1, 32'h4444_4444, 4'hF, 1'b1);
    tick(); chk("t4_drain1", obs, W_I);
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("t4_ifg%0d", i), obs, W_I);
      chk($sformatf("t4_ifg_tready%0d", i), 38'(axis_tready), 38'd0);
    end

    // 5: tlast with tkeep=5, then a clean frame queued during the gap
    drive(1'b1, 32'h1234_5678, 4'h5, 1'b1);
    tick(); chk("t5_s", obs, W_S);
    tick(); chk("t5_p", obs, W_P);
    tick(); chk("t5_err", obs, W_E_TK);
    drive(1'b1, 32'hCCDD_EEFF, 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("t5_ifg%0d", i), obs, W_I);
    end
    tick(); chk("t5_s1", obs, W_S);
    tick(); chk("t5_p1", obs, W_P);
    tick(); chk("t5_d1", obs, wd(32'hCCDD_EEFF));
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick(); chk("t5_t1", obs, W_T);
    repeat (3) tick();

    // 6: async reset during DATA
    drive(1'b1, 32'h5A5A_5A5A, 4'hF, 1'b0);
    tick(); chk("t6_s", obs, W_S);
    tick(); chk("t6_p", obs, W_P);
    tick(); chk("t6_d0", obs, wd(32'h5A5A_5A5A));
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_word", obs, W_I);
    chk("t6_rst_tready", 38'(axis_tready), 38'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(); chk("t6_s_after", obs, W_S);
    tick(); chk("t6_p_after", obs, W_P);
    drive(1'b1, 32'h0000_00C3, 4'h1, 1'b1);
    tick(); chk("t6_term1", obs, {2'b00, 4'hE, 32'h0707_FDC3});
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick(); chk("t6_ifg0", obs, W_I);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
